// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_e            : sequencer state encoding
//   LB..LWU, SB..SD        : RV funct3 encodings for loads and stores
//   byte_mask_to_bit_mask  : expands a per-byte write enable to a per-bit mask
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue0,
    StWait0,
    StIssue1,
    StWait1,
    StResp
  } lsu_state_e;

  // Load funct3
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] LWU = 3'd6;
  // Store funct3
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;
  localparam logic [2:0] SD  = 3'd3;

  // Widest supported beat (XLEN=64); narrower callers zero-extend/truncate.
  localparam int unsigned MaxBeatBytes = 8;

  function automatic logic [8*MaxBeatBytes-1:0] byte_mask_to_bit_mask(
    input logic [MaxBeatBytes-1:0] byte_mask
  );
    logic [8*MaxBeatBytes-1:0] bits;
    for (int i = 0; i < MaxBeatBytes; i++) begin
      bits[8*i +: 8] = {8{byte_mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response channels and memory-side beat channels of the
// load/store unit, bundled in one interface.
//   slave  : view taken by load_store_unit (accepts core requests, drives memory beats)
//   master : view taken by the surrounding core/memory environment
interface load_store_unit_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  // Core side
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [XLEN-1:0]       req_store_data;
  logic                  resp_valid;
  logic [XLEN-1:0]       resp_load_data;
  logic                  resp_fault;
  // Memory side
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [XLEN-1:0]       mem_write_data;
  logic [XLEN-1:0]       mem_write_mask;
  logic                  mem_resp_valid;
  logic [XLEN-1:0]       mem_read_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_store_data,
    input  mem_req_ready, mem_resp_valid, mem_read_data,
    output req_ready, resp_valid, resp_load_data, resp_fault,
    output mem_req_valid, mem_write, mem_address, mem_write_data, mem_write_mask
  );

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_store_data,
    output mem_req_ready, mem_resp_valid, mem_read_data,
    input  req_ready, resp_valid, resp_load_data, resp_fault,
    input  mem_req_valid, mem_write, mem_address, mem_write_data, mem_write_mask
  );
endinterface

// File: rtl/load_data_extender.sv
// Aligns and extends load data.
//   raw_i    : {beat1, beat0} read data (2*XLEN bits)
//   off_i    : byte offset of the access within beat0
//   funct3_i : load funct3 (size in [1:0], zero-extend in [2])
//   data_o   : right-aligned, sign/zero-extended XLEN result
module load_data_extender
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned OffW = $clog2(XLEN / 8),
  localparam int unsigned IdxW = $clog2(XLEN)
) (
  input  logic [2*XLEN-1:0] raw_i,
  input  logic [OffW-1:0]   off_i,
  input  logic [2:0]        funct3_i,
  output logic [XLEN-1:0]   data_o
);

  logic [2*XLEN-1:0] shifted;
  logic [XLEN-1:0]   low;
  logic [XLEN-1:0]   keep;
  logic [IdxW-1:0]   sign_idx;
  logic              sign;

  always_comb begin
    shifted  = raw_i >> {off_i, 3'b000};
    low      = shifted[XLEN-1:0];
    keep     = '1;
    sign_idx = '1;
    unique case (funct3_i[1:0])
      LB[1:0]: begin keep = XLEN'(8'hFF);         sign_idx = IdxW'(7);  end
      LH[1:0]: begin keep = XLEN'(16'hFFFF);      sign_idx = IdxW'(15); end
      LW[1:0]: begin keep = XLEN'(32'hFFFF_FFFF); sign_idx = IdxW'(31); end
      default: begin keep = '1;                   sign_idx = '1;        end
    endcase
    sign   = ~funct3_i[2] & low[sign_idx];
    data_o = (low & keep) | ({XLEN{sign}} & ~keep);
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked load/store unit between the core and the memory bus.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : core request/response and memory beat channels (slave view)
// Accesses that straddle an XLEN/8-byte boundary are split into two aligned
// beats (when ALLOW_MISALIGNED=1); illegal or disallowed accesses complete
// with resp_fault and no memory traffic. One memory beat outstanding at most.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OffW = $clog2(NB);

  // Request decode (only meaningful in StIdle)
  logic [2:0]        req_f3;
  logic [OffW-1:0]   req_off;
  logic              req_legal;
  logic              req_aligned;
  logic              req_fault;
  logic [2*NB-1:0]   req_ones;
  logic [2*NB-1:0]   req_bmask;
  logic [2*XLEN-1:0] req_wdata;

  always_comb begin
    req_f3  = bus.req_funct3;
    req_off = bus.req_address[OffW-1:0];
    if (bus.req_write) begin
      req_legal = !req_f3[2] && !((XLEN == 32) && (req_f3 == SD));
    end else begin
      req_legal = (req_f3 != 3'd7) && !((XLEN == 32) && ((req_f3 == LD) || (req_f3 == LWU)));
    end
    req_ones    = '0;
    req_aligned = 1'b1;
    unique case (req_f3[1:0])
      2'd0:    req_ones = (2*NB)'(8'h01);
      2'd1:    begin req_ones = (2*NB)'(8'h03); req_aligned = !req_off[0];        end
      2'd2:    begin req_ones = (2*NB)'(8'h0F); req_aligned = (req_off[1:0] == 2'd0); end
      default: begin req_ones = (2*NB)'(8'hFF); req_aligned = (req_off == '0);     end
    endcase
    req_fault = !req_legal || (!ALLOW_MISALIGNED && !req_aligned);
    // Byte enables and data span two beats; the upper half belongs to beat1.
    req_bmask = req_ones << req_off;
    req_wdata = {{XLEN{1'b0}}, bus.req_store_data} << {req_off, 3'b000};
  end

  lsu_state_e            state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic                  split_q, split_d;
  logic                  fault_q, fault_d;
  logic [2*NB-1:0]       bmask_q, bmask_d;
  logic [2*XLEN-1:0]     wdata_q, wdata_d;
  logic [2*XLEN-1:0]     rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      addr0_q  <= '0;
      split_q  <= 1'b0;
      fault_q  <= 1'b0;
      bmask_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr0_q  <= addr0_d;
      split_q  <= split_d;
      fault_q  <= fault_d;
      bmask_q  <= bmask_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr0_d  = addr0_q;
    split_d  = split_q;
    fault_d  = fault_q;
    bmask_d  = bmask_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = req_f3;
          off_d    = req_off;
          addr0_d  = {bus.req_address[ADDR_WIDTH-1:OffW], {OffW{1'b0}}};
          split_d  = |req_bmask[2*NB-1:NB];
          fault_d  = req_fault;
          bmask_d  = req_bmask;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          state_d  = req_fault ? StResp : StIssue0;
        end
      end
      StIssue0: if (bus.mem_req_ready) state_d = StWait0;
      StWait0: begin
        if (bus.mem_resp_valid) begin
          if (!write_q) rdata_d[XLEN-1:0] = bus.mem_read_data;
          state_d = split_q ? StIssue1 : StResp;
        end
      end
      StIssue1: if (bus.mem_req_ready) state_d = StWait1;
      StWait1: begin
        if (bus.mem_resp_valid) begin
          if (!write_q) rdata_d[2*XLEN-1:XLEN] = bus.mem_read_data;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic [XLEN-1:0] ext_data;

  load_data_extender #(
    .XLEN(XLEN)
  ) u_extender (
    .raw_i    (rdata_q),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  logic          beat1;
  logic [NB-1:0] beat_bmask;

  always_comb begin
    bus.req_ready      = (state_q == StIdle);
    bus.resp_valid     = (state_q == StResp);
    bus.resp_fault     = (state_q == StResp) && fault_q;
    bus.resp_load_data = ((state_q == StResp) && !write_q && !fault_q) ? ext_data : '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_write_mask = '0;
    beat1              = (state_q == StIssue1);
    beat_bmask         = '0;
    if ((state_q == StIssue0) || (state_q == StIssue1)) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_write     = write_q;
      bus.mem_address   = beat1 ? addr0_q + ADDR_WIDTH'(NB) : addr0_q;
      if (write_q) begin
        bus.mem_write_data = beat1 ? wdata_q[2*XLEN-1:XLEN] : wdata_q[XLEN-1:0];
        beat_bmask         = beat1 ? bmask_q[2*NB-1:NB] : bmask_q[NB-1:0];
        bus.mem_write_mask = XLEN'(byte_mask_to_bit_mask(MaxBeatBytes'(beat_bmask)));
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven, scoreboarded bench for load_store_unit (XLEN=32).
// A second instance with ALLOW_MISALIGNED=0 covers the strict fault path.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) bus  ();
  load_store_unit_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) sbus ();

  load_store_unit #(.XLEN(XLEN), .ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  load_store_unit #(.XLEN(XLEN), .ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus.slave)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } resp_t;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          nbeats;
    int          lat;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [31:0] m0;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic [31:0] m1;
  } vec_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  beat_t mb;
  resp_t mr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_count = 0;
  int resp_cyc = 0;
  logic accept_pending = 1'b0;
  logic hold_resp = 1'b0;
  logic stale_pulse = 1'b0;
  logic [31:0] pend_rdata = '0;
  logic strict_mreq_seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected beats on memory accept and expected responses on resp_valid.
  always @(negedge clk) begin
    if (reset && bus.mem_req_valid && bus.mem_req_ready) begin
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %h expected no beat", bus.mem_address);
      end else begin
        mb = beat_q.pop_front();
        check("beat_addr", 64'(bus.mem_address), 64'(mb.addr));
        check("beat_write", 64'(bus.mem_write), 64'(mb.write));
        if (mb.write) begin
          check("beat_wdata", 64'(bus.mem_write_data), 64'(mb.wdata));
          check("beat_mask", 64'(bus.mem_write_mask), 64'(mb.mask));
        end
        pend_rdata     = mb.rdata;
        accept_pending = 1'b1;
      end
    end
    if (reset && bus.resp_valid) begin
      resp_count++;
      resp_cyc = cyc;
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h expected no response", bus.resp_load_data);
      end else begin
        mr = resp_q.pop_front();
        check("resp_data", 64'(bus.resp_load_data), 64'(mr.data));
        check("resp_fault", 64'(bus.resp_fault), 64'(mr.fault));
      end
    end
    if (sbus.mem_req_valid) strict_mreq_seen = 1'b1;
  end

  // Memory responder: one response the cycle after each accepted beat.
  initial begin
    bus.mem_resp_valid = 1'b0;
    bus.mem_read_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_read_data  = '0;
      if (stale_pulse) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_read_data  = 32'hBAD0_BAD0;
        stale_pulse        = 1'b0;
      end else if (accept_pending && !hold_resp) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_read_data  = pend_rdata;
        accept_pending     = 1'b0;
      end
    end
  end

  task automatic drive_req(input logic write, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, output int t_acc);
    int n;
    @(posedge clk);
    #1;
    bus.req_valid      = 1'b1;
    bus.req_write      = write;
    bus.req_funct3     = f3;
    bus.req_address    = addr;
    bus.req_store_data = sd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1");
    end
    t_acc = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int start_cnt, input int t_acc,
                           input int exp_lat);
    int n;
    n = 0;
    while (resp_count == start_cnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (resp_count == start_cnt) begin
      checks++;
      errors++;
      $display("FAIL %s resp_timeout: got no resp_valid expected one", name);
    end else begin
      check({name, " latency"}, 64'(resp_cyc - t_acc), 64'(exp_lat));
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int t_acc;
    int start_cnt;
    string name;
    name = $sformatf("vec%0d", idx);
    if (v.nbeats > 0) beat_q.push_back('{v.a0, v.write, v.wd0, v.m0, v.rd0});
    if (v.nbeats > 1) beat_q.push_back('{v.a1, v.write, v.wd1, v.m1, v.rd1});
    resp_q.push_back('{v.exp_data, v.exp_fault});
    start_cnt = resp_count;
    drive_req(v.write, v.f3, v.addr, v.sd, t_acc);
    if (v.nbeats > 0) begin
      @(negedge clk);
      check({name, " mem_req_valid_T+1"}, 64'(bus.mem_req_valid), 64'd1);
    end
    wait_resp(name, start_cnt, t_acc, v.lat);
  endtask

  task automatic strict_req(input string name, input logic write, input logic [2:0] f3,
                            input logic [31:0] addr);
    @(posedge clk);
    #1;
    sbus.req_valid      = 1'b1;
    sbus.req_write      = write;
    sbus.req_funct3     = f3;
    sbus.req_address    = addr;
    sbus.req_store_data = 32'h5555_AAAA;
    @(negedge clk);
    check({name, " req_ready"}, 64'(sbus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    sbus.req_valid = 1'b0;
    @(negedge clk);
    check({name, " resp_valid_T+1"}, 64'(sbus.resp_valid), 64'd1);
    check({name, " resp_fault"}, 64'(sbus.resp_fault), 64'd1);
    check({name, " resp_data"}, 64'(sbus.resp_load_data), 64'd0);
    @(negedge clk);
    check({name, " resp_pulse_end"}, 64'(sbus.resp_valid), 64'd0);
  endtask

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_acc;
    int start_cnt;

    //        wr    f3    addr          sd            rd0           rd1
    //        exp_data      flt   nb lat a0          wd0           m0
    //        a1            wd1           m1
    vecs[0]  = '{1'b0, LW, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0,
                 32'hDEADBEEF, 1'b0, 1, 3, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, LB, 32'h103, 32'h0, 32'h80000000, 32'h0,
                 32'hFFFFFF80, 1'b0, 1, 3, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, LBU, 32'h103, 32'h0, 32'h80000000, 32'h0,
                 32'h00000080, 1'b0, 1, 3, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, SH, 32'h102, 32'h00001234, 32'h0, 32'h0,
                 32'h0, 1'b0, 1, 3, 32'h100, 32'h12340000, 32'hFFFF0000, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, LW, 32'h0FE, 32'h0, 32'hAABBCCDD, 32'h11223344,
                 32'h3344AABB, 1'b0, 2, 5, 32'h0FC, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, SW, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h0, 32'h0,
                 32'h0, 1'b0, 2, 5, 32'hFFFFFFFC, 32'hF00D0000, 32'hFFFF0000,
                 32'h0, 32'h0000CAFE, 32'h0000FFFF};
    vecs[6]  = '{1'b0, LH, 32'h101, 32'h0, 32'h12800134, 32'h0,
                 32'hFFFF8001, 1'b0, 1, 3, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, LHU, 32'h103, 32'h0, 32'h77665544, 32'h332211FF,
                 32'h0000FF77, 1'b0, 2, 5, 32'h100, 32'h0, 32'h0, 32'h104, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, SB, 32'h101, 32'hFFFFFFA5, 32'h0, 32'h0,
                 32'h0, 1'b0, 1, 3, 32'h100, 32'hFFFFA500, 32'h0000FF00, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, SW, 32'h108, 32'h01020304, 32'h0, 32'h0,
                 32'h0, 1'b0, 1, 3, 32'h108, 32'h01020304, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b0, LD, 32'h100, 32'h0, 32'h0, 32'h0,
                 32'h0, 1'b1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 3'd7, 32'h100, 32'h0, 32'h0, 32'h0,
                 32'h0, 1'b1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[12] = '{1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 32'h0,
                 32'h0, 1'b1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[13] = '{1'b0, LWU, 32'h100, 32'h0, 32'h0, 32'h0,
                 32'h0, 1'b1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[14] = '{1'b1, SD, 32'h100, 32'h0, 32'h0, 32'h0,
                 32'h0, 1'b1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    bus.req_valid       = 1'b0;
    bus.req_write       = 1'b0;
    bus.req_funct3      = '0;
    bus.req_address     = '0;
    bus.req_store_data  = '0;
    bus.mem_req_ready   = 1'b1;
    sbus.req_valid      = 1'b0;
    sbus.req_write      = 1'b0;
    sbus.req_funct3     = '0;
    sbus.req_address    = '0;
    sbus.req_store_data = '0;
    sbus.mem_req_ready  = 1'b1;
    sbus.mem_resp_valid = 1'b0;
    sbus.mem_read_data  = '0;

    // Reset state
    @(negedge clk);
    check("rst req_ready", 64'(bus.req_ready), 64'd1);
    check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst mem_address", 64'(bus.mem_address), 64'd0);
    check("rst resp_load_data", 64'(bus.resp_load_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Memory backpressure: request must hold steady while mem_req_ready is low.
    bus.mem_req_ready = 1'b0;
    beat_q.push_back('{32'h300, 1'b0, 32'h0, 32'h0, 32'h0BADF00D});
    resp_q.push_back('{32'h0BADF00D, 1'b0});
    start_cnt = resp_count;
    drive_req(1'b0, LW, 32'h300, 32'h0, t_acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
      check("bp mem_address", 64'(bus.mem_address), 64'h300);
      check("bp req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b1;
    wait_resp("backpressure", start_cnt, t_acc, 6);

    // Asynchronous reset while waiting for beat0's response.
    hold_resp = 1'b1;
    beat_q.push_back('{32'h200, 1'b0, 32'h0, 32'h0, 32'h0});
    start_cnt = resp_count;
    drive_req(1'b0, LW, 32'h200, 32'h0, t_acc);
    @(negedge clk);
    @(negedge clk);
    check("wait0 req_ready", 64'(bus.req_ready), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst req_ready", 64'(bus.req_ready), 64'd1);
    check("async_rst mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("async_rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("async_rst mem_address", 64'(bus.mem_address), 64'd0);
    @(negedge clk);
    reset          = 1'b1;
    accept_pending = 1'b0;
    hold_resp      = 1'b0;
    stale_pulse    = 1'b1;
    @(negedge clk);
    check("stale req_ready", 64'(bus.req_ready), 64'd1);
    check("stale resp_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    check("stale no_resp", 64'(resp_count - start_cnt), 64'd0);
    check("stale mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    beat_q.push_back('{32'h200, 1'b0, 32'h0, 32'h0, 32'h600DCAFE});
    resp_q.push_back('{32'h600DCAFE, 1'b0});
    start_cnt = resp_count;
    drive_req(1'b0, LW, 32'h200, 32'h0, t_acc);
    wait_resp("post_reset", start_cnt, t_acc, 3);

    // Strict instance: misaligned and illegal accesses fault without memory traffic.
    strict_req("strict lw_0fe", 1'b0, LW, 32'h0FE);
    strict_req("strict lh_101", 1'b0, LH, 32'h101);
    strict_req("strict f3_7", 1'b0, 3'd7, 32'h100);
    check("strict no_mem_req", 64'(strict_mreq_seen), 64'd0);

    repeat (3) @(negedge clk);
    check("beats_consumed", 64'(beat_q.size()), 64'd0);
    check("resps_consumed", 64'(resp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
